// File: rtl/instr_decode_queue.sv
// Instruction FIFO between fetch and execute that presents the
// full decode of its head entry, with saturating retire statistics.
module instr_decode_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 opcode,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 shamt,
    output logic [4:0]                 aluop,
    output logic [DATA_WIDTH-1:0]      imm,
    output logic [26:0]                target,
    output logic                       is_add,
    output logic                       is_sub,
    output logic                       is_and,
    output logic                       is_or,
    output logic                       is_sll,
    output logic                       is_sra,
    output logic                       is_addi,
    output logic                       is_j,
    output logic                       is_bne,
    output logic                       is_jal,
    output logic                       is_jr,
    output logic                       is_blt,
    output logic                       is_sw,
    output logic                       is_lw,
    output logic                       is_setx,
    output logic                       is_bex,
    output logic                       is_illegal,
    output logic [$clog2(DEPTH):0]     depth_count,
    output logic [CNT_WIDTH-1:0]       retired_count,
    output logic [CNT_WIDTH-1:0]       illegal_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   head;
    logic          push;
    logic          pop;

    assign in_ready    = (count != FULL_CNT);
    assign out_valid   = (count != '0);
    assign depth_count = count;
    assign push        = in_valid & in_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;
    assign head        = mem[rd_ptr];

    // Payload storage carries no reset; only pointers define validity.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count <= '0;
            illegal_count <= '0;
        end else if (pop) begin
            if (retired_count != '1)
                retired_count <= retired_count + CNT_WIDTH'(1);
            if (is_illegal && illegal_count != '1)
                illegal_count <= illegal_count + CNT_WIDTH'(1);
        end
    end

    assign opcode = head[31:27];
    assign rd     = head[26:22];
    assign rs     = head[21:17];
    assign rt     = head[16:12];
    assign shamt  = head[11:7];
    assign aluop  = head[6:2];
    assign target = head[26:0];

    always_comb begin
        imm       = {DATA_WIDTH{head[16]}};
        imm[16:0] = head[16:0];
    end

    // Flags are gated by out_valid so an empty queue never looks like an op.
    always_comb begin
        is_add     = 1'b0;
        is_sub     = 1'b0;
        is_and     = 1'b0;
        is_or      = 1'b0;
        is_sll     = 1'b0;
        is_sra     = 1'b0;
        is_addi    = 1'b0;
        is_j       = 1'b0;
        is_bne     = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        is_blt     = 1'b0;
        is_sw      = 1'b0;
        is_lw      = 1'b0;
        is_setx    = 1'b0;
        is_bex     = 1'b0;
        is_illegal = 1'b0;
        if (out_valid) begin
            case (head[31:27])
                5'b00000: begin
                    case (head[6:2])
                        5'b00000: is_add     = 1'b1;
                        5'b00001: is_sub     = 1'b1;
                        5'b00010: is_and     = 1'b1;
                        5'b00011: is_or      = 1'b1;
                        5'b00100: is_sll     = 1'b1;
                        5'b00101: is_sra     = 1'b1;
                        default:  is_illegal = 1'b1;
                    endcase
                end
                5'b00101: is_addi    = 1'b1;
                5'b00001: is_j       = 1'b1;
                5'b00010: is_bne     = 1'b1;
                5'b00011: is_jal     = 1'b1;
                5'b00100: is_jr      = 1'b1;
                5'b00110: is_blt     = 1'b1;
                5'b00111: is_sw      = 1'b1;
                5'b01000: is_lw      = 1'b1;
                5'b10101: is_setx    = 1'b1;
                5'b10110: is_bex     = 1'b1;
                default:  is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue
// (DEPTH=4, CNT_WIDTH=4 so counter saturation is reachable).
module tb_instr_decode_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
    logic [31:0] imm;
    logic [26:0] target;
    logic        is_add, is_sub, is_and, is_or, is_sll, is_sra;
    logic        is_addi, is_j, is_bne, is_jal, is_jr, is_blt;
    logic        is_sw, is_lw, is_setx, is_bex, is_illegal;
    logic [2:0]  depth_count;
    logic [3:0]  retired_count;
    logic [3:0]  illegal_count;
    logic [16:0] flags;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    assign flags = {is_illegal, is_bex, is_setx, is_lw, is_sw, is_blt,
                    is_jr, is_jal, is_bne, is_j, is_addi, is_sra,
                    is_sll, is_or, is_and, is_sub, is_add};

    instr_decode_queue #(
        .DATA_WIDTH(32),
        .DEPTH(4),
        .CNT_WIDTH(4)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .shamt(shamt), .aluop(aluop), .imm(imm), .target(target),
        .is_add(is_add), .is_sub(is_sub), .is_and(is_and),
        .is_or(is_or), .is_sll(is_sll), .is_sra(is_sra),
        .is_addi(is_addi), .is_j(is_j), .is_bne(is_bne),
        .is_jal(is_jal), .is_jr(is_jr), .is_blt(is_blt),
        .is_sw(is_sw), .is_lw(is_lw), .is_setx(is_setx),
        .is_bex(is_bex), .is_illegal(is_illegal),
        .depth_count(depth_count),
        .retired_count(retired_count),
        .illegal_count(illegal_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] w);
        in_valid = 1'b1;
        in_instr = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || depth_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_flow got v=%0b r=%0b d=%0d want 0 1 0",
                     out_valid, in_ready, depth_count);
        end
        n_checks++;
        if (retired_count !== 4'd0 || illegal_count !== 4'd0 || flags !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got ret=%0d ill=%0d flags=%h want 0 0 0",
                     retired_count, illegal_count, flags);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push_one(32'h0000_0000);
        n_checks++;
        if (out_valid !== 1'b1 || is_add !== 1'b1 || depth_count !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_push got v=%0b add=%0b d=%0d want 1 1 1",
                     out_valid, is_add, depth_count);
        end
        pop_one();
        n_checks++;
        if (retired_count !== 4'd1 || out_valid !== 1'b0 || is_add !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop got ret=%0d v=%0b add=%0b want 1 0 0",
                     retired_count, out_valid, is_add);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (retired_count !== 4'd1 || depth_count !== 3'd0) begin
            n_fail++;
            $display("FAIL empty_pop got ret=%0d d=%0d want 1 0",
                     retired_count, depth_count);
        end
    endtask

    task automatic test_imm();
        do_reset();
        push_one(32'h2801_FFFF);
        push_one(32'h2800_000F);
        n_checks++;
        if (imm !== 32'hFFFF_FFFF || is_addi !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_neg got %h addi=%0b want ffffffff 1", imm, is_addi);
        end
        pop_one();
        n_checks++;
        if (imm !== 32'h0000_000F || is_addi !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_pos got %h addi=%0b want 0000000f 1", imm, is_addi);
        end
        pop_one();
    endtask

    task automatic test_fields();
        do_reset();
        push_one(32'hB0CA_98AA);
        n_checks++;
        if ({opcode, rd, rs, rt, shamt, aluop} !==
            {5'd22, 5'd3, 5'd5, 5'd9, 5'd17, 5'd10}) begin
            n_fail++;
            $display("FAIL fields got op=%0d rd=%0d rs=%0d rt=%0d sh=%0d alu=%0d want 22 3 5 9 17 10",
                     opcode, rd, rs, rt, shamt, aluop);
        end
        n_checks++;
        if (imm !== 32'h0000_98AA || target !== 27'h0CA_98AA || is_bex !== 1'b1) begin
            n_fail++;
            $display("FAIL fields_imm got imm=%h tgt=%h bex=%0b want 000098aa 0ca98aa 1",
                     imm, target, is_bex);
        end
        pop_one();
    endtask

    task automatic test_decode();
        logic [31:0] vec [18];
        int          idx [18];
        vec = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
                32'h0000_0010, 32'h0000_0014, 32'h2800_0000, 32'h0800_0000,
                32'h1000_0000, 32'h1800_0000, 32'h2000_0000, 32'h3000_0000,
                32'h3800_0000, 32'h4000_0000, 32'hA800_0000, 32'hB000_0000,
                32'h0000_0018, 32'h4800_0000};
        idx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 16};
        do_reset();
        for (int i = 0; i < 18; i++) begin
            push_one(vec[i]);
            n_checks++;
            if (flags !== (17'd1 << idx[i])) begin
                n_fail++;
                $display("FAIL decode_%0d instr=%h got flags=%h want %h",
                         i, vec[i], flags, 17'd1 << idx[i]);
            end
            pop_one();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++)
            push_one(32'h0800_0100 + 32'(i));
        n_checks++;
        if (in_ready !== 1'b0 || depth_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full got r=%0b d=%0d want 0 4", in_ready, depth_count);
        end
        push_one(32'h0800_0999);
        n_checks++;
        if (depth_count !== 3'd4 || target !== 27'h100) begin
            n_fail++;
            $display("FAIL full_drop got d=%0d tgt=%h want 4 100", depth_count, target);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (target !== 27'(32'h100 + 32'(i))) begin
                n_fail++;
                $display("FAIL order_%0d got %h want %h", i, target, 32'h100 + 32'(i));
            end
            pop_one();
        end
        n_checks++;
        if (depth_count !== 3'd0 || out_valid !== 1'b0 || retired_count !== 4'd4) begin
            n_fail++;
            $display("FAIL drain got d=%0d v=%0b ret=%0d want 0 0 4",
                     depth_count, out_valid, retired_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++)
            push_one(32'h0800_0100 + 32'(i));
        in_valid = 1'b1;
        in_instr = 32'h0800_0555;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (depth_count !== 3'd3 || in_ready !== 1'b1 || target !== 27'h101) begin
            n_fail++;
            $display("FAIL full_pop got d=%0d r=%0b tgt=%h want 3 1 101",
                     depth_count, in_ready, target);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (depth_count !== 3'd3 || target !== 27'h102) begin
            n_fail++;
            $display("FAIL push_pop got d=%0d tgt=%h want 3 102", depth_count, target);
        end
        pop_one();
        pop_one();
        n_checks++;
        if (target !== 27'h555 || depth_count !== 3'd1) begin
            n_fail++;
            $display("FAIL push_pop_tail got tgt=%h d=%0d want 555 1", target, depth_count);
        end
        pop_one();
    endtask

    task automatic test_illegal();
        do_reset();
        push_one(32'h0000_001C);
        push_one(32'hF800_0000);
        n_checks++;
        if (is_illegal !== 1'b1 || flags !== 17'h10000) begin
            n_fail++;
            $display("FAIL illegal_alu got ill=%0b flags=%h want 1 10000", is_illegal, flags);
        end
        pop_one();
        n_checks++;
        if (is_illegal !== 1'b1 || illegal_count !== 4'd1) begin
            n_fail++;
            $display("FAIL illegal_op got ill=%0b cnt=%0d want 1 1", is_illegal, illegal_count);
        end
        pop_one();
        n_checks++;
        if (illegal_count !== 4'd2 || retired_count !== 4'd2) begin
            n_fail++;
            $display("FAIL illegal_cnt got ill=%0d ret=%0d want 2 2",
                     illegal_count, retired_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++)
            push_one(32'hF800_0000);
        pop_one();
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0000_0000;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (depth_count !== 3'd0 || out_valid !== 1'b0 || flags !== 17'd0) begin
            n_fail++;
            $display("FAIL flush got d=%0d v=%0b flags=%h want 0 0 0",
                     depth_count, out_valid, flags);
        end
        n_checks++;
        if (retired_count !== 4'd1 || illegal_count !== 4'd1) begin
            n_fail++;
            $display("FAIL flush_cnt got ret=%0d ill=%0d want 1 1",
                     retired_count, illegal_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push_one(32'h0000_001C);
            pop_one();
            if (i == 15) begin
                n_checks++;
                if (retired_count !== 4'hF || illegal_count !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sat16 got ret=%h ill=%h want f f",
                             retired_count, illegal_count);
                end
            end
        end
        n_checks++;
        if (retired_count !== 4'hF || illegal_count !== 4'hF) begin
            n_fail++;
            $display("FAIL sat17 got ret=%h ill=%h want f f", retired_count, illegal_count);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 4; i++)
            push_one(32'h0000_0004);
        pop_one();
        push_one(32'h0000_0004);
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || depth_count !== 3'd0 ||
            retired_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid got r=%0b v=%0b d=%0d ret=%0d want 1 0 0 0",
                     in_ready, out_valid, depth_count, retired_count);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_imm();
        test_fields();
        test_decode();
        test_full();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_saturation();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised successor to the single-cycle instruction decoder.
- Buffers fetched 32-bit instructions in a DEPTH-entry FIFO and presents the full decode of the head entry.
- Decode covers all fields, a sign-extended immediate, a jump target, one-hot instruction-class flags and an illegal flag.
- Sits between fetch and execute, with valid/ready handshakes on both sides, a flush input and saturating statistics counters.

Parameters:
- DATA_WIDTH, 32: width of the sign-extended immediate output; must be >= 17.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronously discards all queued entries.
- in_valid, input, 1: fetch presents an instruction.
- in_ready, output, 1: queue can accept; equals !full.
- in_instr, input, 32: instruction word.
- out_valid, output, 1: head entry present; equals !empty.
- out_ready, input, 1: execute consumes the head entry.
- opcode, output, 5: head instr[31:27].
- rd, output, 5: head instr[26:22].
- rs, output, 5: head instr[21:17].
- rt, output, 5: head instr[16:12].
- shamt, output, 5: head instr[11:7].
- aluop, output, 5: head instr[6:2].
- imm, output, DATA_WIDTH: instr[16:0] sign-extended from bit 16.
- target, output, 27: instr[26:0] zero-extended.
- is_add, is_sub, is_and, is_or, is_sll, is_sra, output, 1 each: R-type (opcode 00000) with aluop 00000..00101 respectively.
- is_addi, is_j, is_bne, is_jal, is_jr, is_blt, is_sw, is_lw, is_setx, is_bex, output, 1 each: opcode 00101, 00001, 00010, 00011, 00100, 00110, 00111, 01000, 10101, 10110 respectively.
- is_illegal, output, 1: opcode matches none of the above, or R-type with aluop > 00101.
- depth_count, output, $clog2(DEPTH)+1: current occupancy.
- retired_count, output, CNT_WIDTH: number of pops.
- illegal_count, output, CNT_WIDTH: number of pops whose head entry had is_illegal=1.

Behaviour:
- Reset: while reset=1 at a rising edge, the following clear:
  - read and write pointers and occupancy; out_valid=0, in_ready=1, depth_count=0;
  - both counters to 0.
- Reset has priority over every other input.
- Storage: raw instructions are stored in FIFO entries that are not reset. Pointers wrap modulo DEPTH.
- Push and pop conditions:
  - push = in_valid & in_ready & !flush;
  - pop = out_valid & out_ready & !flush.
- Latency: an instruction pushed at edge N is visible on the decode outputs immediately after edge N. There is no empty-queue bypass; minimum latency is 1 cycle.
- Decode outputs are purely combinational from the head entry. They change only after clock edges.
- When out_valid=0:
  - all is_* flags, including is_illegal, are driven 0;
  - field outputs are don't-care.
- Exactly one is_* flag (including is_illegal) is 1 whenever out_valid=1.
- Full queue: in_ready=0 and pushes are blocked. A pop in the same cycle does not allow a push in that cycle; in_ready reasserts the next cycle.
- Empty queue: an asserted out_ready is ignored.
- Simultaneous push and pop when neither full nor empty: both occur and occupancy is unchanged.
- Flush:
  - at the edge, pointers and occupancy clear and the queued entries are discarded;
  - a concurrent push is dropped, a concurrent pop is not counted;
  - counters are held.
- Counters: on each pop, retired_count increments by 1. illegal_count also increments by 1 if the popped head has is_illegal=1. Both saturate at all-ones and never wrap.
- depth_count changes as follows:
  - +1 on push only;
  - -1 on pop only;
  - 0 on push and pop together, or on neither.

Test Plan:
- Reset, then push 0x00000000 (add) -> next cycle out_valid=1 and is_add=1; on pop, retired_count=1.
- Push addi with instr[16:0]=0x1FFFF -> imm=0xFFFFFFFF; push 0x0000F -> imm=0x0000000F; is_addi=1 for both.
- Push DEPTH=4 entries with out_ready=0 -> in_ready=0 and depth_count=4; a fifth push is ignored; pop 4 -> entries emerge in order and depth_count=0.
- Push R-type with aluop=00111, then opcode 11111 -> is_illegal=1 for both; after popping both, illegal_count=2.
- Queue holds 3 entries; flush=1 with in_valid=1 and out_ready=1 -> next cycle depth_count=0 and out_valid=0, counters unchanged.
- Force retired_count to all-ones via CNT_WIDTH=4 build with 16 pops -> it stays 0xF after a 17th pop. Also: asserting reset in mid-stream with the queue full -> in_ready=1 and out_valid=0 on the next cycle.
